// File: rtl/gps_pack_pkg.sv
// Shared widths, nibble layout and saturating-count helper for the GPS sample packer.
// Pure definitions: no latency, no flow control.
package gps_pack_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int SAMPLES_PER_WORD = 4;
  localparam int WORD_W           = 16;
  localparam int DROP_CNT_W       = 8;
  localparam int PHASE_W          = $clog2(SAMPLES_PER_WORD);
  localparam int SHIFT_W          = WORD_W - NIBBLE_W;

  // I1 is the MSB so a nibble reads {I1, I0, Q1, Q0}.
  typedef struct packed {
    logic i1;
    logic i0;
    logic q1;
    logic q0;
  } nibble_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gps_sync_fifo.sv
// First-word-fall-through FIFO; head visible combinationally, push/pop take effect on the same edge.
// A push while full is accepted only when a pop happens on that edge; otherwise the caller drops it.
module gps_sync_fifo #(
  parameter int FIFO_AW = 3,
  parameter int WORD_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push_vld,
  input  logic [WORD_W-1:0] i_push_dat,
  input  logic              i_pop_rdy,
  output logic [WORD_W-1:0] o_head_dat,
  output logic              o_head_vld,
  output logic              o_full,
  output logic              o_empty,
  output logic [FIFO_AW:0]  o_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0]  r_wptr;
  logic [FIFO_AW:0]  r_rptr;
  logic [FIFO_AW:0]  w_level;
  logic              w_pop;
  logic              w_push_acc;

  assign w_level    = r_wptr - r_rptr;
  assign o_level    = w_level;
  assign o_empty    = (w_level == '0);
  assign o_full     = (w_level == (FIFO_AW+1)'(DEPTH));
  assign o_head_vld = !o_empty;
  assign o_head_dat = r_mem[r_rptr[FIFO_AW-1:0]];

  // When full, the write slot equals the head slot, which is being read out this edge.
  assign w_pop      = i_pop_rdy && !o_empty;
  assign w_push_acc = i_push_vld && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_acc) begin
        r_mem[r_wptr[FIFO_AW-1:0]] <= i_push_dat;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gps_sample_packer.sv
// Packs four contiguous enabled GPS samples into a 16-bit word (out of FIFO one edge after the 4th capture).
// Full FIFO drops new words (sticky OVERFLOW, saturating DROP_COUNT); GPS_PACK_TESTPAT_EN adds a counter test pattern.
module gps_sample_packer
  import gps_pack_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic                  GPS_CLK_16_368,
  input  logic                  RESET_N,
  input  logic                  GPS_I0,
  input  logic                  GPS_I1,
  input  logic                  GPS_Q0,
  input  logic                  GPS_Q1,
  input  logic                  ENABLE,
  input  logic                  OVF_CLEAR,
`ifdef GPS_PACK_TESTPAT_EN
  input  logic                  TEST_MODE,
`endif
  output logic [WORD_W-1:0]     WORD_DATA,
  output logic                  WORD_VALID,
  input  logic                  WORD_READY,
  output logic                  OVERFLOW,
  output logic [DROP_CNT_W-1:0] DROP_COUNT,
  output logic [FIFO_AW:0]      FILL_LEVEL
);

  nibble_t               w_pin_nib;
  nibble_t               w_cap_nib;
  nibble_t               r_s_nib;
  logic                  r_s_val;
  logic [PHASE_W-1:0]    r_phase;
  logic [SHIFT_W-1:0]    r_sh;
  logic                  w_push;
  logic [WORD_W-1:0]     w_word;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  r_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  assign w_pin_nib = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};

`ifdef GPS_PACK_TESTPAT_EN
  logic [NIBBLE_W-1:0] r_tp_cnt;

  always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tp_cnt <= '0;
    end else if (!ENABLE) begin
      r_tp_cnt <= '0;
    end else begin
      r_tp_cnt <= r_tp_cnt + 1'b1;
    end
  end

  assign w_cap_nib = TEST_MODE ? nibble_t'(r_tp_cnt) : w_pin_nib;
`else
  assign w_cap_nib = w_pin_nib;
`endif

  always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s_nib <= '0;
      r_s_val <= 1'b0;
    end else begin
      r_s_nib <= w_cap_nib;
      r_s_val <= ENABLE;
    end
  end

  // Phase 3 completes a word; a gap in s_val restarts the count so partial words vanish.
  assign w_push = r_s_val && (r_phase == PHASE_W'(SAMPLES_PER_WORD - 1));
  assign w_word = {r_sh, r_s_nib};

  always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_phase <= '0;
      r_sh    <= '0;
    end else if (!r_s_val || w_push) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
      r_sh    <= {r_sh[SHIFT_W-NIBBLE_W-1:0], r_s_nib};
    end
  end

  gps_sync_fifo #(
    .FIFO_AW (FIFO_AW),
    .WORD_W  (WORD_W)
  ) u_fifo (
    .i_clk      (GPS_CLK_16_368),
    .i_rst_n    (RESET_N),
    .i_push_vld (w_push),
    .i_push_dat (w_word),
    .i_pop_rdy  (WORD_READY),
    .o_head_dat (WORD_DATA),
    .o_head_vld (WORD_VALID),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (FILL_LEVEL)
  );

  assign w_drop = w_push && w_full && !(!w_empty && WORD_READY);

  // A drop coinciding with a clear restarts the count at one rather than zero.
  always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      r_drop_cnt <= OVF_CLEAR ? DROP_CNT_W'(1) : sat_inc(r_drop_cnt);
    end else if (OVF_CLEAR) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign OVERFLOW   = r_ovf;
  assign DROP_COUNT = r_drop_cnt;

endmodule
